branch_resolve_queue: RTL and testbench
=======================================

# branch_resolve_queue

Holds in-flight gshare predictions between prediction and branch resolution, then pairs each resolved outcome with its oldest outstanding prediction. Sits directly downstream of the `gshare` predictor, consuming its `prediction` and `branch_pc` per branch. It produces a registered update/mispredict record, from which predictor training and flush logic are driven. Optional counters provide branch and misprediction statistics in hardware, replacing bench-side counting.

## Interface
Parameters:
- `DEPTH`, 8: queue entries; power of two, ≥ 2.
- `PC_W`, 8: branch PC width; matches `gshare` `branch_pc`.
- `CNT_W`, 16: statistics counter width.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pred_valid`  in  1  prediction present this cycle.
- `pred_pc`  in  PC_W  PC of predicted branch.
- `pred_taken`  in  1  predicted direction from `gshare`.
- `pred_ready`  out  1  queue accepts a push; combinational, equals `!full`.
- `res_valid`  in  1  oldest outstanding branch resolved this cycle.
- `res_taken`  in  1  actual outcome.
- `flush`  in  1  discard all queued entries.
- `upd_valid`  out  1  registered update record valid.
- `upd_pc`  out  PC_W  PC of resolved branch.
- `upd_outcome`  out  1  actual outcome, for predictor training.
- `mispredict`  out  1  predicted ≠ actual; qualified by `upd_valid`.
- `full`, `empty`  out  1 each  occupancy flags.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `underflow_err`  out  1  sticky: `res_valid` arrived while empty.
- `branch_count`, `mispredict_count`  out  CNT_W each  statistics; present only with the statistics macro defined.

## Operation
- Circular buffer with head/tail pointers of $clog2(DEPTH) bits, wrapping DEPTH-1 → 0, plus the occupancy counter `count`. `full` = (`count` == DEPTH); `empty` = (`count` == 0).
- Push: `pred_valid && pred_ready` writes {`pred_pc`, `pred_taken`} at tail; tail advances.
- Pop: `res_valid && !empty` reads head; head advances. Next cycle: `upd_valid`=1, `upd_pc`=head PC, `upd_outcome`=`res_taken`, `mispredict`=(head taken ≠ `res_taken`).
- When no pop occurs, `upd_valid`=0 next cycle. `upd_pc`, `upd_outcome` and `mispredict` hold their last values.
- Push and pop in the same cycle: both performed; `count` unchanged.
- Full: `pred_ready`=0 and the push is refused, even if a pop occurs the same cycle (no bypass). The upstream stage holds.
- Empty with `res_valid`: no pop, `upd_valid`=0, `underflow_err` set. A same-cycle push is not bypassed to the pop.
- `flush`: pointers and `count` cleared next cycle. Flush beats a same-cycle push or pop, and that pop produces no update. `underflow_err` is unaffected.
- `underflow_err` clears only on `reset`.
- Reset: pointers, `count`, `upd_valid`, `upd_pc`, `upd_outcome`, `mispredict`, `underflow_err` and counters all go to 0. Consequently `empty`=1, `full`=0, `pred_ready`=1.
- Entry storage is not reset.

## Timing
- Push-to-occupancy latency: 1 cycle. `count`, `full` and `empty` reflect a push after the following edge.
- Resolve-to-update latency: 1 cycle; `upd_*` and `mispredict` are registered.
- Throughput: one push and one pop per cycle.
- `reset` asserted mid-operation discards all entries at that edge. Any pending update is suppressed.
- Counters update on the same edge that asserts `upd_valid`.

## Configuration
- `BRQ_STATS_EN` defined:
  - `branch_count` increments on every pop.
  - `mispredict_count` increments on every pop with a mismatch.
  - Both saturate at 2^CNT_W−1 and are not cleared by `flush`.
- `BRQ_STATS_EN` undefined: both counter ports and their logic are absent; all other behaviour is identical.

## Test plan
- Reset, then push PC=5 taken; resolve with `res_taken`=0 → next cycle `upd_valid`=1, `upd_pc`=5, `upd_outcome`=0, `mispredict`=1.
- Push 8 entries (DEPTH=8) → `full`=1, `pred_ready`=0. A 9th push is refused. Pop all 8 → PCs returned in order 0..7, then `empty`=1.
- Run 20 cycles of simultaneous push and pop at occupancy 3 → `count` stays 3, pointers wrap, outputs are in FIFO order.
- `res_valid` with queue empty → `upd_valid`=0, `underflow_err`=1 and still 1 after 10 idle cycles; cleared only by `reset`.
- `flush` at occupancy 4 with a same-cycle push and pop → `count`=0, `empty`=1, no `upd_valid` pulse.
- With `BRQ_STATS_EN`: 10 resolves, 3 mismatched → `branch_count`=10, `mispredict_count`=3. Forcing CNT_W=2 → both counters saturate at 3.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// In-flight branch prediction queue: pairs each resolved outcome with its oldest prediction.
// Optional statistics counters are enabled by defining BRQ_STATS_EN.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pred_valid,
  input  logic [PC_W-1:0]            pred_pc,
  input  logic                       pred_taken,
  output logic                       pred_ready,
  input  logic                       res_valid,
  input  logic                       res_taken,
  input  logic                       flush,
  output logic                       upd_valid,
  output logic [PC_W-1:0]            upd_pc,
  output logic                       upd_outcome,
  output logic                       mispredict,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       underflow_err
`ifdef BRQ_STATS_EN
  ,
  output logic [CNT_W-1:0]           branch_count,
  output logic [CNT_W-1:0]           mispredict_count
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [PC_W-1:0]  pcMem    [DEPTH];
  logic             takenMem [DEPTH];

  logic [PTR_W-1:0] headPtr_q, headPtr_d;
  logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             updValid_q, updValid_d;
  logic [PC_W-1:0]  updPc_q, updPc_d;
  logic             updOutcome_q, updOutcome_d;
  logic             mispredict_q, mispredict_d;
  logic             underflow_q, underflow_d;

  logic doPush;
  logic doPop;

  assign full       = (count_q == OCC_W'(DEPTH));
  assign empty      = (count_q == '0);
  assign pred_ready = !full;

  // Flush wins over both a same-cycle push and pop; a pop never bypasses a push.
  assign doPush = pred_valid && pred_ready && !flush;
  assign doPop  = res_valid && !empty && !flush;

  always_comb begin
    headPtr_d    = headPtr_q;
    tailPtr_d    = tailPtr_q;
    count_d      = count_q;
    updValid_d   = doPop;
    updPc_d      = updPc_q;
    updOutcome_d = updOutcome_q;
    mispredict_d = mispredict_q;
    underflow_d  = underflow_q || (res_valid && empty);

    if (doPush) begin
      tailPtr_d = tailPtr_q + PTR_W'(1);
    end
    if (doPop) begin
      headPtr_d    = headPtr_q + PTR_W'(1);
      updPc_d      = pcMem[headPtr_q];
      updOutcome_d = res_taken;
      mispredict_d = takenMem[headPtr_q] != res_taken;
    end

    case ({doPush, doPop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      headPtr_d = '0;
      tailPtr_d = '0;
      count_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      headPtr_q    <= '0;
      tailPtr_q    <= '0;
      count_q      <= '0;
      updValid_q   <= 1'b0;
      updPc_q      <= '0;
      updOutcome_q <= 1'b0;
      mispredict_q <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      headPtr_q    <= headPtr_d;
      tailPtr_q    <= tailPtr_d;
      count_q      <= count_d;
      updValid_q   <= updValid_d;
      updPc_q      <= updPc_d;
      updOutcome_q <= updOutcome_d;
      mispredict_q <= mispredict_d;
      underflow_q  <= underflow_d;
    end
  end

  // Entry storage carries no reset; occupancy tracking alone decides validity.
  always_ff @(posedge clk) begin
    if (doPush) begin
      pcMem[tailPtr_q]    <= pred_pc;
      takenMem[tailPtr_q] <= pred_taken;
    end
  end

  assign upd_valid     = updValid_q;
  assign upd_pc        = updPc_q;
  assign upd_outcome   = updOutcome_q;
  assign mispredict    = mispredict_q;
  assign count         = count_q;
  assign underflow_err = underflow_q;

`ifdef BRQ_STATS_EN
  logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
  logic [CNT_W-1:0] mispCnt_q, mispCnt_d;

  // Saturating counters; flush deliberately leaves them alone.
  always_comb begin
    branchCnt_d = branchCnt_q;
    mispCnt_d   = mispCnt_q;
    if (doPop && branchCnt_q != '1) begin
      branchCnt_d = branchCnt_q + CNT_W'(1);
    end
    if (doPop && (takenMem[headPtr_q] != res_taken) && mispCnt_q != '1) begin
      mispCnt_d = mispCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branchCnt_q <= '0;
      mispCnt_q   <= '0;
    end else begin
      branchCnt_q <= branchCnt_d;
      mispCnt_q   <= mispCnt_d;
    end
  end

  assign branch_count     = branchCnt_q;
  assign mispredict_count = mispCnt_q;
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue (DEPTH=8, PC_W=8).
module tb_branch_resolve_queue;

  logic       clk;
  logic       reset;
  logic       pred_valid;
  logic [7:0] pred_pc;
  logic       pred_taken;
  logic       pred_ready;
  logic       res_valid;
  logic       res_taken;
  logic       flush;
  logic       upd_valid;
  logic [7:0] upd_pc;
  logic       upd_outcome;
  logic       mispredict;
  logic       full;
  logic       empty;
  logic [3:0] count;
  logic       underflow_err;
`ifdef BRQ_STATS_EN
  logic [15:0] branch_count;
  logic [15:0] mispredict_count;
  logic        s_pred_ready, s_upd_valid, s_upd_outcome, s_mispredict;
  logic        s_full, s_empty, s_underflow_err;
  logic [7:0]  s_upd_pc;
  logic [3:0]  s_count;
  logic [1:0]  s_branch_count;
  logic [1:0]  s_mispredict_count;
`endif

  int passCount;
  int totalCount;

  branch_resolve_queue #(.DEPTH(8), .PC_W(8), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_outcome(upd_outcome),
    .mispredict(mispredict), .full(full), .empty(empty), .count(count),
    .underflow_err(underflow_err)
`ifdef BRQ_STATS_EN
    , .branch_count(branch_count), .mispredict_count(mispredict_count)
`endif
  );

`ifdef BRQ_STATS_EN
  // Narrow-counter copy sharing the same stimulus, used to observe saturation.
  branch_resolve_queue #(.DEPTH(8), .PC_W(8), .CNT_W(2)) dutSat (
    .clk(clk), .reset(reset),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
    .pred_ready(s_pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
    .upd_valid(s_upd_valid), .upd_pc(s_upd_pc), .upd_outcome(s_upd_outcome),
    .mispredict(s_mispredict), .full(s_full), .empty(s_empty), .count(s_count),
    .underflow_err(s_underflow_err),
    .branch_count(s_branch_count), .mispredict_count(s_mispredict_count)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle so registered outputs are stable.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    totalCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  initial begin
    passCount  = 0;
    totalCount = 0;
    reset      = 1'b1;
    pred_valid = 1'b0;
    pred_pc    = '0;
    pred_taken = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    flush      = 1'b0;
    step();
    step();
    reset = 1'b0;

    checkOutput("rst_count", 32'(count), 32'd0);
    checkOutput("rst_empty", 32'(empty), 32'd1);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_ready", 32'(pred_ready), 32'd1);
    checkOutput("rst_updv", 32'(upd_valid), 32'd0);
    checkOutput("rst_updpc", 32'(upd_pc), 32'd0);
    checkOutput("rst_uflow", 32'(underflow_err), 32'd0);

    // Single push then mispredicted resolve.
    pred_valid = 1'b1; pred_pc = 8'd5; pred_taken = 1'b1;
    step();
    pred_valid = 1'b0;
    checkOutput("push1_count", 32'(count), 32'd1);
    checkOutput("push1_empty", 32'(empty), 32'd0);
    res_valid = 1'b1; res_taken = 1'b0;
    step();
    res_valid = 1'b0;
    checkOutput("res1_updv", 32'(upd_valid), 32'd1);
    checkOutput("res1_pc", 32'(upd_pc), 32'd5);
    checkOutput("res1_outc", 32'(upd_outcome), 32'd0);
    checkOutput("res1_misp", 32'(mispredict), 32'd1);
    checkOutput("res1_count", 32'(count), 32'd0);
    step();
    checkOutput("idle_updv", 32'(upd_valid), 32'd0);
    checkOutput("idle_pc_hold", 32'(upd_pc), 32'd5);
    checkOutput("idle_misp_hold", 32'(mispredict), 32'd1);

    // Fill to DEPTH; taken alternates with PC LSB.
    for (int i = 0; i < 8; i++) begin
      pred_valid = 1'b1; pred_pc = 8'(i); pred_taken = i[0];
      step();
    end
    pred_valid = 1'b0;
    checkOutput("fill_full", 32'(full), 32'd1);
    checkOutput("fill_ready", 32'(pred_ready), 32'd0);
    checkOutput("fill_count", 32'(count), 32'd8);
    pred_valid = 1'b1; pred_pc = 8'd99; pred_taken = 1'b0;
    step();
    checkOutput("push9_refused", 32'(count), 32'd8);

    // Drain with res_taken=1; first pop also carries a (refused) push.
    for (int i = 0; i < 8; i++) begin
      res_valid = 1'b1; res_taken = 1'b1;
      step();
      pred_valid = 1'b0;
      if (i == 0) checkOutput("full_pop_no_bypass", 32'(count), 32'd7);
      checkOutput($sformatf("drain_pc%0d", i), 32'(upd_pc), 32'(i));
      checkOutput($sformatf("drain_misp%0d", i), 32'(mispredict), 32'(!i[0]));
    end
    res_valid = 1'b0;
    checkOutput("drain_empty", 32'(empty), 32'd1);
    checkOutput("drain_count", 32'(count), 32'd0);

    // Steady state at occupancy 3 with concurrent push/pop.
    for (int i = 0; i < 3; i++) begin
      pred_valid = 1'b1; pred_pc = 8'(100 + i); pred_taken = 1'b0;
      step();
    end
    for (int k = 0; k < 20; k++) begin
      pred_valid = 1'b1; pred_pc = 8'(103 + k); pred_taken = 1'b0;
      res_valid = 1'b1; res_taken = k[0];
      step();
      checkOutput($sformatf("pp_count%0d", k), 32'(count), 32'd3);
      checkOutput($sformatf("pp_pc%0d", k), 32'(upd_pc), 32'(100 + k));
      checkOutput($sformatf("pp_misp%0d", k), 32'(mispredict), 32'(k[0]));
    end
    res_valid = 1'b0;
    pred_pc = 8'd200;
    step();
    pred_valid = 1'b0;
    checkOutput("pre_flush_count", 32'(count), 32'd4);

    // Flush with same-cycle push and pop.
    flush = 1'b1; pred_valid = 1'b1; pred_pc = 8'd201; res_valid = 1'b1; res_taken = 1'b0;
    step();
    flush = 1'b0; pred_valid = 1'b0; res_valid = 1'b0;
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_empty", 32'(empty), 32'd1);
    checkOutput("flush_updv", 32'(upd_valid), 32'd0);
    checkOutput("flush_uflow", 32'(underflow_err), 32'd0);

    // Resolve while empty, with a same-cycle push that must not bypass.
    res_valid = 1'b1; res_taken = 1'b1; pred_valid = 1'b1; pred_pc = 8'd77; pred_taken = 1'b1;
    step();
    res_valid = 1'b0; pred_valid = 1'b0;
    checkOutput("uflow_updv", 32'(upd_valid), 32'd0);
    checkOutput("uflow_set", 32'(underflow_err), 32'd1);
    checkOutput("uflow_count", 32'(count), 32'd1);
    for (int i = 0; i < 10; i++) step();
    checkOutput("uflow_sticky", 32'(underflow_err), 32'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("uflow_after_flush", 32'(underflow_err), 32'd1);
    checkOutput("flush2_count", 32'(count), 32'd0);

    // Mid-operation reset suppresses a pending update.
    pred_valid = 1'b1; pred_pc = 8'd42; pred_taken = 1'b0;
    step();
    pred_valid = 1'b0;
    res_valid = 1'b1; res_taken = 1'b1; reset = 1'b1;
    step();
    res_valid = 1'b0; reset = 1'b0;
    checkOutput("mrst_updv", 32'(upd_valid), 32'd0);
    checkOutput("mrst_count", 32'(count), 32'd0);
    checkOutput("mrst_uflow", 32'(underflow_err), 32'd0);
    checkOutput("mrst_pc", 32'(upd_pc), 32'd0);

`ifdef BRQ_STATS_EN
    // Ten resolves, the first three mismatched.
    for (int k = 0; k < 10; k++) begin
      pred_valid = 1'b1; pred_pc = 8'(k); pred_taken = 1'b1;
      step();
      pred_valid = 1'b0;
      res_valid = 1'b1; res_taken = (k >= 3);
      step();
      res_valid = 1'b0;
    end
    checkOutput("stat_branch", 32'(branch_count), 32'd10);
    checkOutput("stat_misp", 32'(mispredict_count), 32'd3);
    checkOutput("sat_branch", 32'(s_branch_count), 32'd3);
    checkOutput("sat_misp", 32'(s_mispredict_count), 32'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checkOutput("stat_keep_flush", 32'(branch_count), 32'd10);
`endif

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
